// File: rtl/ef_gpio8_ahbl.sv
// 8-bit GPIO with AHB-Lite register slave and 32-source sticky interrupt block.
// Define EF_GPIO8_AHBL_SYNC_EN to pass io_in through a 2-flop synchronizer.
module ef_gpio8_ahbl (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        IRQ,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
    output logic [7:0]  io_oe
);
    localparam logic [15:0] ADDR_DATAI = 16'h0000;
    localparam logic [15:0] ADDR_DATAO = 16'h0004;
    localparam logic [15:0] ADDR_DIR   = 16'h0008;
    localparam logic [15:0] ADDR_IM    = 16'h0F00;
    localparam logic [15:0] ADDR_MIS   = 16'h0F04;
    localparam logic [15:0] ADDR_RIS   = 16'h0F08;
    localparam logic [15:0] ADDR_IC    = 16'h0F0C;

    logic        hvld_q, hvld_d;
    logic        hwrite_q, hwrite_d;
    logic [15:0] haddr_q, haddr_d;
    logic [7:0]  data_o_q, data_o_d;
    logic [7:0]  dir_q, dir_d;
    logic [31:0] im_q, im_d;
    logic [31:0] ris_q, ris_d;
    logic [7:0]  sync_q, sync_d;
    logic [7:0]  s_d_q, s_d_d;
    logic        bus_we;
    logic [31:0] ic_clr;
    logic [31:0] ris_set;

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HADDR[31:16]};

`ifdef EF_GPIO8_AHBL_SYNC_EN
    logic [7:0] meta_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) meta_q <= '0;
        else        meta_q <= io_in;
    end

    assign sync_d = meta_q;
`else
    assign sync_d = io_in;
`endif

    always_comb begin
        hvld_d   = HSEL & HTRANS[1] & HREADY;
        hwrite_d = hwrite_q;
        haddr_d  = haddr_q;
        if (hvld_d) begin
            hwrite_d = HWRITE;
            haddr_d  = HADDR[15:0];
        end

        bus_we   = hvld_q & hwrite_q;
        data_o_d = data_o_q;
        dir_d    = dir_q;
        im_d     = im_q;
        ic_clr   = '0;
        if (bus_we) begin
            case (haddr_q)
                ADDR_DATAO: data_o_d = HWDATA[7:0];
                ADDR_DIR:   dir_d    = HWDATA[7:0];
                ADDR_IM:    im_d     = HWDATA;
                ADDR_IC:    ic_clr   = HWDATA;
                default:    ;
            endcase
        end

        // Sources are re-evaluated every cycle, so applying the set after the
        // clear lets a persisting condition win over a simultaneous IC write.
        ris_set = {~sync_q & s_d_q, sync_q & ~s_d_q, ~sync_q, sync_q};
        ris_d   = (ris_q & ~ic_clr) | ris_set;
        s_d_d   = sync_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hvld_q   <= 1'b0;
            hwrite_q <= 1'b0;
            haddr_q  <= '0;
            data_o_q <= '0;
            dir_q    <= '0;
            im_q     <= '0;
            ris_q    <= '0;
            sync_q   <= '0;
            s_d_q    <= '0;
        end else begin
            hvld_q   <= hvld_d;
            hwrite_q <= hwrite_d;
            haddr_q  <= haddr_d;
            data_o_q <= data_o_d;
            dir_q    <= dir_d;
            im_q     <= im_d;
            ris_q    <= ris_d;
            sync_q   <= sync_d;
            s_d_q    <= s_d_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (hvld_q && !hwrite_q) begin
            case (haddr_q)
                ADDR_DATAI: HRDATA = {24'h0, sync_q};
                ADDR_DATAO: HRDATA = {24'h0, data_o_q};
                ADDR_DIR:   HRDATA = {24'h0, dir_q};
                ADDR_IM:    HRDATA = im_q;
                ADDR_MIS:   HRDATA = ris_q & im_q;
                ADDR_RIS:   HRDATA = ris_q;
                default:    HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign IRQ       = |(ris_q & im_q);
    assign io_out    = data_o_q;
    assign io_oe     = dir_q;
endmodule

// File: tb/tb_ef_gpio8_ahbl.sv
// Randomized scoreboard bench for ef_gpio8_ahbl with a cycle-level reference model.
module tb_ef_gpio8_ahbl;
`ifdef EF_GPIO8_AHBL_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, IRQ;
    logic [31:0] HRDATA;
    logic [7:0]  io_in, io_out, io_oe;

    ef_gpio8_ahbl dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .IRQ(IRQ),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic mon_en = 1'b0;
    logic mon_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pad history, registers, sticky status and pending bus transfer.
    logic [7:0]  m_hist[0:2];
    logic [7:0]  m_do, m_dir;
    logic [31:0] m_im, m_ris;
    logic        m_pv, m_pw;
    logic [15:0] m_pa;

    function automatic logic [31:0] sources(input logic [7:0] s, input logic [7:0] sd);
        logic [31:0] r = '0;
        for (int p = 0; p < 8; p++) begin
            if (s[p]) r[p] = 1'b1; else r[8+p] = 1'b1;
            if (s[p] && !sd[p]) r[16+p] = 1'b1;
            if (!s[p] && sd[p]) r[24+p] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a)
            16'h0000: return {24'h0, m_hist[SYNC-1]};
            16'h0004: return {24'h0, m_do};
            16'h0008: return {24'h0, m_dir};
            16'h0F00: return m_im;
            16'h0F04: return m_ris & m_im;
            16'h0F08: return m_ris;
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_hist[0] <= '0; m_hist[1] <= '0; m_hist[2] <= '0;
            m_do <= '0; m_dir <= '0; m_im <= '0; m_ris <= '0;
            m_pv <= 1'b0; m_pw <= 1'b0; m_pa <= '0;
        end else begin
            if (m_pv && m_pw && m_pa == 16'h0004) m_do <= HWDATA[7:0];
            if (m_pv && m_pw && m_pa == 16'h0008) m_dir <= HWDATA[7:0];
            if (m_pv && m_pw && m_pa == 16'h0F00) m_im <= HWDATA;
            m_ris <= (m_ris & ~((m_pv && m_pw && m_pa == 16'h0F0C) ? HWDATA : 32'h0))
                     | sources(m_hist[SYNC-1], m_hist[SYNC]);
            m_hist[0] <= io_in; m_hist[1] <= m_hist[0]; m_hist[2] <= m_hist[1];
            m_pv <= HSEL & HTRANS[1] & HREADY;
            if (HSEL && HTRANS[1] && HREADY) begin
                m_pa <= HADDR[15:0];
                m_pw <= HWRITE;
            end
        end
    end

    // Monitor: pin outputs every cycle, read data whenever a read data phase is active.
    always @(posedge HCLK) mon_rd <= !HRESET && HSEL && HTRANS[1] && HREADY && !HWRITE;

    always @(negedge HCLK) begin
        if (mon_en) begin
            chk("io_out", {24'h0, io_out}, {24'h0, m_do});
            chk("io_oe", {24'h0, io_oe}, {24'h0, m_dir});
            chk("irq", {31'h0, IRQ}, {31'h0, |(m_ris & m_im)});
            chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
            if (mon_rd) begin
                if (exp_q.size() == 0) chk("rd_unexpected", HRDATA, 32'hDEADBEEF);
                else chk("hrdata", HRDATA, exp_q.pop_front());
            end
        end
    end

    // One address phase; HWDATA for this transfer is presented in the following cycle.
    task automatic issue(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic rdy,
                         input logic use_c, input logic [31:0] c);
        logic acc_rd;
        HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = addr; HREADY = rdy;
        HSIZE = 3'($urandom_range(0, 7));
        acc_rd = sel && tr[1] && rdy && !wr && !HRESET;
        @(posedge HCLK); #1;
        if (acc_rd) exp_q.push_back(use_c ? c : m_read(addr[15:0]));
        HWDATA = wd;
        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, 2'b10, 1'b1, a, d, 1'b1, 1'b0, 32'h0);
    endtask
    task automatic rd(input logic [31:0] a);
        issue(1'b1, 2'b10, 1'b0, a, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask
    task automatic rdc(input logic [31:0] a, input logic [31:0] c);
        issue(1'b1, 2'b10, 1'b0, a, 32'h0, 1'b1, 1'b1, c);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    logic [15:0] amap[9];

    initial begin
        amap = '{16'h0000, 16'h0004, 16'h0008, 16'h0F00, 16'h0F04, 16'h0F08, 16'h0F0C,
                 16'h0010, 16'h07FC};
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
        HADDR = '0; HWDATA = '0; HSIZE = 3'b010; io_in = 8'h00;
        @(posedge HCLK); #1;
        mon_en = 1'b1;
        idle(1);
        HRESET = 1'b0;
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        chk("rst_oe", {24'h0, io_oe}, 32'h0);
        chk("rst_out", {24'h0, io_out}, 32'h0);
        rdc(32'h0004, 32'h0); rdc(32'h0008, 32'h0); rdc(32'h0F00, 32'h0);
        rdc(32'h0000, 32'h0);

        wr(32'h0008, 32'hFF); wr(32'h0004, 32'hA5); idle(1);
        chk("out_oe", {24'h0, io_oe}, 32'hFF);
        chk("out_data", {24'h0, io_out}, 32'hA5);
        rdc(32'h0004, 32'hA5);
        wr(32'h0008, 32'h00); rdc(32'h0008, 32'h0);

        io_in = 8'hAB; idle(3);
        rdc(32'h0000, 32'hAB);

        io_in = 8'h00; idle(4);
        wr(32'h0F00, 32'h0001_0000); wr(32'h0F0C, 32'hFFFF_FFFF); idle(1);
        chk("rise_pre_irq", {31'h0, IRQ}, 32'h0);
        io_in = 8'h01; idle(4);
        chk("rise_irq", {31'h0, IRQ}, 32'h1);
        rdc(32'h0F04, 32'h0001_0000);
        wr(32'h0F0C, 32'h0001_0000); idle(1);
        chk("rise_clr_irq", {31'h0, IRQ}, 32'h0);

        io_in = 8'h80; wr(32'h0F00, 32'h80); idle(4);
        chk("lvl_irq", {31'h0, IRQ}, 32'h1);
        wr(32'h0F0C, 32'h80); idle(2);
        chk("lvl_persist", {31'h0, IRQ}, 32'h1);
        rdc(32'h0F04, 32'h80);

        rdc(32'h0010, 32'h0);
        wr(32'h0010, 32'hFFFF_FFFF);
        rdc(32'h0004, 32'hA5); rdc(32'h0008, 32'h0); rdc(32'h0F00, 32'h80);
        rdc(32'h0F0C, 32'h0);

        wr(32'h0004, 32'h3C);
        HRESET = 1'b1; idle(1); HRESET = 1'b0;
        chk("midrst_out", {24'h0, io_out}, 32'h0);
        rdc(32'h0F00, 32'h0);

        for (int it = 0; it < 800; it++) begin
            logic [31:0] a;
            int k;
            if ($urandom_range(0, 3) == 0) io_in = 8'($urandom);
            a = {16'($urandom), amap[$urandom_range(0, 8)]};
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: wr(a, $urandom);
                3, 4, 5: rd(a);
                6:       idle(1);
                7:       issue(1'b0, 2'b10, $urandom_range(0, 1) == 1, a, 32'h0, 1'b1, 1'b0, 32'h0);
                8:       issue(1'b1, 2'b01, $urandom_range(0, 1) == 1, a, 32'h0, 1'b1, 1'b0, 32'h0);
                default: begin
                    idle(1);
                    issue(1'b1, 2'b10, $urandom_range(0, 1) == 1, a, 32'h0, 1'b0, 1'b0, 32'h0);
                end
            endcase
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ef_gpio8_ahbl.md
# ef_gpio8_ahbl

8-bit general-purpose I/O port with an AHB-Lite slave register interface and a 32-source interrupt block. It sits on the peripheral AHB-Lite bus. Software sets per-pin direction, drives output data, reads synchronized pad inputs, and takes level/edge interrupts through a single IRQ line.

## Interface
Parameters:
- none.

Ports:
- HCLK  in  1  bus and core clock; all logic on the rising edge.
- HRESET  in  1  reset, synchronous and active-high; clears all state on the next HCLK edge.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only HADDR[15:0] is decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ (valid).
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  ignored; all accesses are treated as 32-bit words.
- HREADY  in  1  bus-ready from the interconnect.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  tied to 1; zero wait states.
- HRDATA  out  32  read data, valid in the data phase.
- IRQ  out  1  interrupt request, equal to |MIS.
- io_in  in  8  pad inputs.
- io_out  out  8  pad output data, equal to DATAO[7:0].
- io_oe  out  8  pad output enables, equal to DIR[7:0]; 1 means the pin is an output.

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY; the block registers HADDR[15:0] and HWRITE.
- Writes take effect on the clock edge that ends the data phase, using HWDATA.
- Reads return HRDATA combinationally from the registered address during the data phase.
- Unmapped addresses read 0; writes to them are ignored.

Register map (offsets in hex; unused bits read 0):
- 0x0000 DATAI, RO, [7:0]: synchronized io_in.
- 0x0004 DATAO, RW, [7:0]: drives io_out.
- 0x0008 DIR, RW, [7:0]: drives io_oe.
- 0x0F00 IM, RW, [31:0]: interrupt mask.
- 0x0F04 MIS, RO: RIS & IM.
- 0x0F08 RIS, RO, [31:0]: raw interrupt status.
- 0x0F0C IC, WO, W1C: writing 1 to bit n clears RIS[n]. Reads return 0.

RIS source mapping, for pin p = 0..7, evaluated on the synchronized input s and its previous sample s_d:
- [p] sets while s[p]=1 (high level).
- [8+p] sets while s[p]=0 (low level).
- [16+p] sets on a rising edge (s[p]=1, s_d[p]=0).
- [24+p] sets on a falling edge (s[p]=0, s_d[p]=1).
- RIS bits are sticky until cleared through IC.
- If a set and an IC clear hit the same bit in the same cycle, the set wins.

Pin behaviour:
- Direction does not gate input sampling; DATAI always reflects the pads.
- io_out is driven regardless of io_oe.

## Timing
- Reset values: DATAO=0, DIR=0, IM=0, RIS=0, sync stages=0, s_d=0.
  - Outputs after reset: io_out=0, io_oe=0, IRQ=0, HREADYOUT=1, HRDATA=0.
- Write to DATAO or DIR: io_out or io_oe changes on the edge ending the data phase.
- Input path latency from io_in to DATAI: see Configuration. RIS updates one cycle after s changes.
- IRQ is combinational from the RIS and IM registers.
  - It asserts in the same cycle a masked RIS bit sets.
  - It deasserts the cycle after an IC write clears the last masked pending bit.
- Back-to-back transfers are supported. A read immediately following a write to the same register returns the new value.
- If HRESET asserts mid-transfer, the pending transfer is abandoned and all registers reset.

## Configuration
- EF_GPIO8_AHBL_SYNC_EN defined: io_in passes through a 2-flop synchronizer. DATAI reflects a pad change 2 cycles later; edge flags take 3 cycles.
- Not defined: a single register stage. DATAI latency is 1 cycle; edge flags take 2 cycles.

## Test plan
- Reset: read all registers after reset -> DATAO=0, DIR=0, IM=0, RIS=0; io_oe=0x00, io_out=0x00, IRQ=0.
- Output: write DIR=0xFF, then DATAO=0xA5 -> io_oe=0xFF and io_out=0xA5 within 1 cycle; DATAO reads back 0xA5.
- Input: write DIR=0x00, set io_in=0xAB, wait 3 cycles, read DATAI -> 0x000000AB.
- Rising edge: io_in=0x00, write IM=0x00010000, IC=0xFFFFFFFF; then set io_in[0]=1 -> RIS[16]=1, MIS=0x00010000, IRQ=1; write IC=0x00010000 -> IRQ=0 next cycle.
- Level persistence: io_in=0x80, write IM=0x80 -> IRQ stays 1 after IC=0x80, because set wins while the level persists.
- Unmapped: read 0x0010 -> 0; write 0x0010 -> no register changes.
